bv_match_encode: RTL
====================

BV_MATCH_ENCODE -- requirements
Module: bv_match_encode

Interface
REQ-001 SHALL have parameter BV_WIDTH, default 288, meaning the rule bit-vector width (one bit per rule).
REQ-002 SHALL have parameter CHUNK, default 32, meaning the bits scanned per cycle; BV_WIDTH SHALL be an integer multiple of CHUNK (NUM_CHUNKS = BV_WIDTH/CHUNK, 9 by default).
REQ-003 SHALL have parameter IDX_W, default 9, meaning the rule-index width; 2^IDX_W SHALL be >= BV_WIDTH.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 stage_enable_in  input  1  one-cycle start pulse from the preceding one-clock enable-hold stage.
REQ-007 bv_a, bv_b, bv_c  input  BV_WIDTH each  per-field match vectors; valid in the cycle stage_enable_in is high.
REQ-008 stage_enable_out  output  1  one-cycle pulse, result valid.
REQ-009 match_hit  output  1  1 = at least one rule matched.
REQ-010 match_index  output  IDX_W  lowest-numbered matching rule; 0 on miss.
REQ-011 busy  output  1  high while scanning.
REQ-012 enable_lost  output  1  sticky flag, start pulse dropped while busy.

Function
REQ-013 SHALL implement two states, IDLE and SCAN; busy SHALL equal (state == SCAN).
REQ-014 In IDLE with stage_enable_in=1 at edge E0: latch vec = bv_a & bv_b & bv_c, set chunk counter cnt=0, go to SCAN.
REQ-015 In IDLE with stage_enable_in=0: hold state; all outputs hold, except stage_enable_out, which is 0.
REQ-016 In SCAN at each edge: examine vec[cnt*CHUNK +: CHUNK].
REQ-017 If that chunk is nonzero: match_hit=1, match_index = cnt*CHUNK + position of its lowest set bit, stage_enable_out=1, return to IDLE.
REQ-018 If the chunk is zero and cnt < NUM_CHUNKS-1: cnt increments and the block stays in SCAN.
REQ-019 If the chunk is zero and cnt = NUM_CHUNKS-1: match_hit=0, match_index=0, stage_enable_out=1, return to IDLE.
REQ-020 Latency: a hit in chunk k SHALL pulse stage_enable_out in the cycle after edge E0+1+k; a miss SHALL pulse after edge E0+NUM_CHUNKS.
REQ-021 stage_enable_out SHALL be high for exactly one cycle per accepted start.
REQ-022 match_hit and match_index SHALL hold their values until the next result.
REQ-023 stage_enable_in=1 while in SCAN, including the edge that completes the scan, SHALL be ignored and SHALL set enable_lost=1.
REQ-024 enable_lost SHALL be cleared only by reset.
REQ-025 A start is accepted at the first IDLE edge; there is no back-to-back acceptance on the completion edge.
REQ-026 bv inputs SHALL be sampled only at the accepting edge; later changes to them SHALL not affect the scan in progress.
REQ-027 Priority: the lowest bit index SHALL win, both within and across chunks.

Reset
REQ-028 While reset=0, outputs SHALL be: state=IDLE, cnt=0, vec=0, stage_enable_out=0, match_hit=0, match_index=0, busy=0, enable_lost=0.
REQ-029 Reset SHALL take effect asynchronously, including mid-SCAN.
REQ-030 The in-progress scan SHALL be aborted with no stage_enable_out pulse.
REQ-031 After reset releases, the first stage_enable_in SHALL be accepted normally.

Verification
REQ-032 Hit in chunk 0: bv_a=bv_b=bv_c with bit 5 set, one pulse -> after 1 cycle: stage_enable_out=1, match_hit=1, match_index=5.
REQ-033 Multi-field AND: bv_a bits {3,70,200}, bv_b bits {70,200}, bv_c bits {200,70} -> match at chunk 2 after 3 cycles, match_index=70; busy high for 3 cycles.
REQ-034 Miss: bv_a=all ones, bv_b=0 -> after 9 cycles: stage_enable_out=1, match_hit=0, match_index=0; busy high for 9 cycles.
REQ-035 Boundary: only bit 287 set in all three vectors -> match_index=287 after 9 cycles.
REQ-036 Busy collision: a second pulse during SCAN and another on the completion edge -> both ignored, enable_lost=1, exactly one stage_enable_out.
REQ-037 Busy collision follow-up: a pulse on the next IDLE edge -> accepted.
REQ-038 Reset mid-SCAN: assert reset at cnt=4 -> all outputs 0 immediately, no pulse; after release, a new scan with bit 10 set -> match_index=10.

Source files
------------

// File: rtl/bv_match_encode.sv
// ---------------------------------------------------------------------------
// bv_match_encode
//
// Purpose:
//   Combines three per-field rule match vectors with a bitwise AND, then scans
//   the result CHUNK bits per cycle. It reports the lowest-numbered rule whose
//   bit survives the AND. Each start pulse gives exactly one result pulse. A
//   start that arrives while a scan is running is dropped, and the drop is
//   remembered in a sticky flag.
//
// Parameters:
//   BV_WIDTH  rule bit-vector width, one bit per rule (multiple of CHUNK)
//   CHUNK     bits examined per scan cycle
//   IDX_W     rule index width (2**IDX_W >= BV_WIDTH)
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous, active-low reset
//   stage_enable_in   one-cycle start pulse; bv_a/b/c are sampled with it
//   bv_a, bv_b, bv_c  per-field match vectors
//   stage_enable_out  one-cycle pulse, match_hit/match_index are valid
//   match_hit         1 = at least one rule matched (held until next result)
//   match_index       lowest matching rule, 0 on miss (held until next result)
//   busy              high while a scan is in progress
//   enable_lost       sticky: a start pulse was dropped while busy
// ---------------------------------------------------------------------------
module bv_match_encode #(
  parameter int BV_WIDTH = 288,
  parameter int CHUNK    = 32,
  parameter int IDX_W    = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stage_enable_in,
  input  logic [BV_WIDTH-1:0] bv_a,
  input  logic [BV_WIDTH-1:0] bv_b,
  input  logic [BV_WIDTH-1:0] bv_c,
  output logic                stage_enable_out,
  output logic                match_hit,
  output logic [IDX_W-1:0]    match_index,
  output logic                busy,
  output logic                enable_lost
);

  localparam int NUM_CHUNKS = BV_WIDTH / CHUNK;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [BV_WIDTH-1:0] vec;
  logic [BV_WIDTH-1:0] vec_nxt;
  logic                seo_nxt;
  logic                hit_nxt;
  logic [IDX_W-1:0]    idx_nxt;
  logic                lost_nxt;

  logic [CHUNK-1:0]    cur_chunk;
  logic                chunk_nz;
  logic [IDX_W-1:0]    chunk_base;
  logic [IDX_W-1:0]    chunk_off;
  logic [IDX_W-1:0]    chunk_idx;

  assign busy = (state == SCAN);

  // Select the chunk of the latched vector addressed by the chunk counter.
  // The vector is frozen at the accepting edge, so input changes during the
  // scan never reach this path.
  always_comb begin
    cur_chunk = vec[int'(cnt) * CHUNK +: CHUNK];
  end

  // Priority encoder for the current chunk. The loop runs from the top bit
  // down, so the last assignment that takes effect is the lowest set bit.
  // Because chunks are visited in ascending order and the scan stops at the
  // first nonzero chunk, the lowest index also wins across chunks.
  always_comb begin
    chunk_nz   = |cur_chunk;
    chunk_base = IDX_W'(int'(cnt) * CHUNK);
    chunk_off  = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (cur_chunk[i]) begin
        chunk_off = IDX_W'(i);
      end
    end
    chunk_idx = chunk_base + chunk_off;
  end

  // Next-state and next-output logic. Every register holds by default, and
  // the result pulse defaults low. This gives the one-cycle pulse and the
  // hold-until-next-result behaviour of match_hit/match_index.
  // A start pulse seen in SCAN, even on the completing edge, only sets the
  // sticky lost flag. Acceptance therefore only happens from IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vec_nxt   = vec;
    seo_nxt   = 1'b0;
    hit_nxt   = match_hit;
    idx_nxt   = match_index;
    lost_nxt  = enable_lost;

    case (state)
      IDLE: begin
        if (stage_enable_in) begin
          vec_nxt   = bv_a & bv_b & bv_c;
          cnt_nxt   = '0;
          state_nxt = SCAN;
        end
      end

      SCAN: begin
        if (stage_enable_in) begin
          lost_nxt = 1'b1;
        end
        if (chunk_nz) begin
          hit_nxt   = 1'b1;
          idx_nxt   = chunk_idx;
          seo_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == LAST_CNT) begin
          hit_nxt   = 1'b0;
          idx_nxt   = '0;
          seo_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous, so it aborts a scan
  // in progress immediately. The result pulse is cleared with everything
  // else, so an aborted scan never produces stage_enable_out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      vec              <= '0;
      stage_enable_out <= 1'b0;
      match_hit        <= 1'b0;
      match_index      <= '0;
      enable_lost      <= 1'b0;
    end else begin
      state            <= state_nxt;
      cnt              <= cnt_nxt;
      vec              <= vec_nxt;
      stage_enable_out <= seo_nxt;
      match_hit        <= hit_nxt;
      match_index      <= idx_nxt;
      enable_lost      <= lost_nxt;
    end
  end

endmodule
